// File: rtl/latch_mem_driver.sv
// Host-side driver for a latch-based word memory: sequences address/data setup,
// a registered write strobe and hold for writes, and a timed sample for reads.
module latch_mem_driver #(
  parameter int SETUP_CYCLES = 1,  // 1..15
  parameter int WE_CYCLES    = 1,  // 1..15
  parameter int HOLD_CYCLES  = 1,  // 1..15
  parameter int READ_WAIT    = 2   // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [7:0] mem_ui_in,
  output logic [7:0] mem_uio_in,
  input  logic [7:0] mem_uo_out
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RWAIT,
    RESP
  } state_t;

  // Counters hold "cycles remaining minus one", so a state exits when it reads zero.
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WE_LOAD    = 4'(WE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] RWAIT_LOAD = 4'(READ_WAIT - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       write_reg, write_next;
  logic [5:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       wr_en_reg, wr_en_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic [7:0] rdata_reg, rdata_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      write_reg     <= 1'b0;
      addr_reg      <= 6'd0;
      wdata_reg     <= 8'd0;
      wr_en_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wr_en_reg     <= wr_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wr_en_next     = 1'b0;
    rsp_valid_next = rsp_valid_reg;
    rdata_next     = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          write_next = req_write;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          cnt_next   = SETUP_LOAD;
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (cnt_reg == 4'd0) begin
          if (write_reg) begin
            // wr_en is a register, so it is set on the edge that enters STROBE.
            wr_en_next = 1'b1;
            cnt_next   = WE_LOAD;
            state_next = STROBE;
          end else begin
            cnt_next   = RWAIT_LOAD;
            state_next = RWAIT;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      STROBE: begin
        if (cnt_reg == 4'd0) begin
          cnt_next   = HOLD_LOAD;
          state_next = HOLD;
        end else begin
          wr_en_next = 1'b1;
          cnt_next   = cnt_reg - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      RWAIT: begin
        if (cnt_reg == 4'd0) begin
          rdata_next     = mem_uo_out;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rdata_reg;
  assign mem_ui_in  = {wr_en_reg, 1'b0, addr_reg};
  assign mem_uio_in = wdata_reg;

endmodule

// File: tb/tb_latch_mem_driver.sv
// Bench for latch_mem_driver: a default-timing instance and a slow-timing instance,
// each attached to a behavioural latch memory, driven by directed and random transactions.
module tb_latch_mem_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write, rsp_ready;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  int         sel;

  logic       vld   [2];
  logic       rrdy  [2];
  logic       ready [2];
  logic       rvalid[2];
  logic [7:0] rdata [2];
  logic [7:0] ui    [2];
  logic [7:0] uio   [2];
  logic [7:0] uo    [2];

  logic [7:0] mem    [2][64];
  logic [7:0] shadow [2][64];

  logic       poke_en;
  int         poke_sel;
  logic [5:0] poke_addr;
  logic [7:0] poke_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      vld[s]  = req_valid && (sel == s);
      rrdy[s] = rsp_ready && (sel == s);
      uo[s]   = mem[s][ui[s][5:0]];
    end
  end

  // Latch memory: stores while its write enable is high; the bench can also overwrite cells.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (ui[s][7] === 1'b1) mem[s][ui[s][5:0]] <= uio[s];
    if (poke_en) mem[poke_sel][poke_addr] <= poke_data;
  end

  latch_mem_driver u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(vld[0]), .req_ready(ready[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rvalid[0]), .rsp_ready(rrdy[0]), .rsp_rdata(rdata[0]),
    .mem_ui_in(ui[0]), .mem_uio_in(uio[0]), .mem_uo_out(uo[0])
  );

  latch_mem_driver #(
    .SETUP_CYCLES(3), .WE_CYCLES(2), .HOLD_CYCLES(4), .READ_WAIT(5)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(vld[1]), .req_ready(ready[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rvalid[1]), .rsp_ready(rrdy[1]), .rsp_rdata(rdata[1]),
    .mem_ui_in(ui[1]), .mem_uio_in(uio[1]), .mem_uo_out(uo[1])
  );

  function automatic int sc(int s); return (s == 1) ? 3 : 1; endfunction
  function automatic int wc(int s); return (s == 1) ? 2 : 1; endfunction
  function automatic int hc(int s); return (s == 1) ? 4 : 1; endfunction
  function automatic int rw(int s); return (s == 1) ? 5 : 2; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int s, input logic [5:0] a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_sel  = s;
    poke_addr = a;
    poke_data = d;
    shadow[s][a] = d;
  endtask

  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 6'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Entered and left at a falling edge with the selected driver idle.
  task automatic do_write(input int s, input logic [5:0] a, input logic [7:0] d);
    int S = sc(s);
    int W = wc(s);
    int H = hc(s);
    sel = s;
    chk("wr_ready_pre", ready[s], 1);
    req_write = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= S + W + H; k++) begin
      @(negedge clk);
      chk("wr_ui", ui[s], (k > S && k <= S + W) ? {2'b10, a} : {2'b00, a});
      chk("wr_uio", uio[s], d);
      chk("wr_busy_ready", ready[s], 0);
      noise();
    end
    @(negedge clk);
    req_valid = 1'b0;
    shadow[s][a] = d;
    chk("wr_ready_back", ready[s], 1);
    chk("wr_idle_ui", ui[s], {2'b00, a});
    chk("wr_idle_uio", uio[s], d);
    $display("dut%0d write addr=%02h data=%02h", s, a, d);
  endtask

  task automatic do_read(input int s, input logic [5:0] a, input int hold,
                         input bit twiddle, input bit abort);
    int S = sc(s);
    int R = rw(s);
    logic [7:0] exp_d;
    sel = s;
    chk("rd_ready_pre", ready[s], 1);
    req_write = 1'b0; req_addr = a; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= S + R; k++) begin
      @(negedge clk);
      poke_en = 1'b0;
      chk("rd_ui", ui[s], {2'b00, a});
      chk("rd_busy_ready", ready[s], 0);
      chk("rd_early_valid", rvalid[s], 0);
      noise();
      // Changing the cell one cycle before capture pins down the sample edge.
      if (twiddle && k == S + R - 1) poke(s, a, shadow[s][a] ^ 8'h5A);
    end
    @(negedge clk);
    poke_en = 1'b0;
    req_valid = 1'b0;
    exp_d = shadow[s][a];
    chk("rd_valid", rvalid[s], 1);
    chk("rd_data", rdata[s], exp_d);
    chk("rd_resp_ready", ready[s], 0);
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_resp_valid", rvalid[s], 0);
      chk("rst_resp_data", rdata[s], 0);
      chk("rst_resp_ready", ready[s], 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp_ready_back", ready[s], 1);
      $display("dut%0d read addr=%02h aborted by reset", s, a);
      return;
    end
    if (hold > 0) poke(s, a, ~exp_d);
    for (int j = 0; j < hold; j++) begin
      noise();
      @(negedge clk);
      poke_en = 1'b0;
      chk("rd_hold_valid", rvalid[s], 1);
      chk("rd_hold_data", rdata[s], exp_d);
      chk("rd_hold_ready", ready[s], 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rd_done_valid", rvalid[s], 0);
    chk("rd_done_ready", ready[s], 1);
    $display("dut%0d read addr=%02h data=%02h hold=%0d", s, a, exp_d, hold);
  endtask

  initial begin
    logic [5:0] ra;
    int         rs;
    rst = 1'b1; sel = 0;
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = 6'd0; req_wdata = 8'd0;
    poke_en = 1'b0; poke_sel = 0; poke_addr = 6'd0; poke_data = 8'd0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_ui", ui[s], 0);
      chk("reset_uio", uio[s], 0);
      chk("reset_rsp_valid", rvalid[s], 0);
      chk("reset_rdata", rdata[s], 0);
      chk("reset_ready", ready[s], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk("post_reset_ready", ready[s], 1);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) begin
        poke(s, 6'(i), 8'($urandom));
        @(negedge clk);
      end
    poke_en = 1'b0;
    @(negedge clk);

    // Default timing: write then read back, then a stalled response.
    do_write(0, 6'h2A, 8'hC3);
    do_read(0, 6'h2A, 0, 1'b0, 1'b0);
    do_read(0, 6'h11, 5, 1'b1, 1'b0);

    // Reset in the middle of a write strobe.
    sel = 0;
    chk("strobe_ready_pre", ready[0], 1);
    req_write = 1'b1; req_addr = 6'h15; req_wdata = 8'h7E; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("strobe_setup_ui", ui[0], 8'h15);
    @(negedge clk);
    chk("strobe_ui", ui[0], 8'h95);
    rst = 1'b1;
    @(posedge clk);
    #1;
    shadow[0][6'h15] = 8'h7E;
    chk("rst_strobe_ui", ui[0], 0);
    chk("rst_strobe_uio", uio[0], 0);
    chk("rst_strobe_valid", rvalid[0], 0);
    chk("rst_strobe_rdata", rdata[0], 0);
    chk("rst_strobe_ready", ready[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobe_ready_back", ready[0], 1);
    $display("dut0 write addr=15 aborted by reset in strobe");
    do_write(0, 6'h3F, 8'h5C);
    do_read(0, 6'h3F, 1, 1'b0, 1'b0);
    do_read(0, 6'h15, 0, 1'b0, 1'b0);

    // Reset with a read response pending.
    do_read(0, 6'h07, 0, 1'b0, 1'b1);

    // Slow timing: back-to-back traffic at both address extremes.
    do_write(1, 6'h00, 8'hA5);
    do_read(1, 6'h00, 0, 1'b1, 1'b0);
    do_write(1, 6'h3F, 8'h3C);
    do_read(1, 6'h3F, 2, 1'b0, 1'b0);
    do_read(1, 6'h00, 0, 1'b0, 1'b0);

    repeat (24) begin
      rs = $urandom_range(0, 1);
      ra = 6'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(rs, ra, 8'($urandom));
      else
        do_read(rs, ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_mem_driver.md
LATCH_MEM_DRIVER -- requirements
Module: latch_mem_driver

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1: cycles address/data are driven before wr_en rises (legal range 1..15).
REQ-002 SHALL have parameter WE_CYCLES, default 1: cycles wr_en is held high (legal range 1..15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1: cycles address/data are held after wr_en falls (legal range 1..15).
REQ-004 SHALL have parameter READ_WAIT, default 2: cycles address is driven before read data is sampled (legal range 1..15).
REQ-005 clk  input  1  sole clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  host request present.
REQ-008 req_ready  output  1  driver can accept a request.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  6  target word address.
REQ-011 req_wdata  input  8  write data.
REQ-012 rsp_valid  output  1  read data available.
REQ-013 rsp_ready  input  1  host consumes read data.
REQ-014 rsp_rdata  output  8  read data.
REQ-015 mem_ui_in  output  8  to memory dedicated inputs: bit7 wr_en, bit6 constant 0, bits5:0 address.
REQ-016 mem_uio_in  output  8  to memory write-data pins.
REQ-017 mem_uo_out  input  8  from memory read-data pins.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RWAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE while rst = 0; a request is accepted on a rising edge where req_valid && req_ready.
REQ-020 On acceptance, the driver SHALL latch req_write, req_addr and req_wdata, drive them on mem_ui_in[5:0] and mem_uio_in from the next cycle, and enter SETUP.
REQ-021 SETUP SHALL last exactly SETUP_CYCLES cycles with wr_en = 0, then go to STROBE (write) or RWAIT (read).
REQ-022 STROBE SHALL last exactly WE_CYCLES cycles with wr_en = 1, then go to HOLD.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles with wr_en = 0, then go to IDLE.
REQ-024 Address and write data SHALL remain constant from the first SETUP cycle through the last HOLD cycle.
REQ-025 wr_en SHALL be registered, glitch-free, and high only in STROBE.
REQ-026 RWAIT SHALL last exactly READ_WAIT cycles with wr_en = 0; mem_uo_out SHALL be captured into rsp_rdata on the edge that ends the last RWAIT cycle; next state RESP.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_rdata SHALL stay stable until an edge with rsp_ready = 1; that edge returns the FSM to IDLE and clears rsp_valid.
REQ-028 If the acceptance edge is cycle 0, a write SHALL make req_ready = 1 again in cycle 1+SETUP_CYCLES+WE_CYCLES+HOLD_CYCLES (cycle 4 at defaults).
REQ-029 If the acceptance edge is cycle 0, a read SHALL assert rsp_valid in cycle 1+SETUP_CYCLES+READ_WAIT (cycle 4 at defaults).
REQ-030 In IDLE, mem_ui_in[5:0] and mem_uio_in SHALL keep their last driven values, and wr_en SHALL be 0.
REQ-031 mem_ui_in[6] SHALL always be 0.
REQ-032 Request inputs SHALL be ignored outside IDLE; there SHALL be no queuing.
REQ-033 Cycle counters SHALL be 4 bits wide, SHALL reload on each state entry, and SHALL NOT wrap within a state.

Reset
REQ-034 While rst = 1 at a rising edge, the next state SHALL be: FSM in IDLE, mem_ui_in = 0x00, mem_uio_in = 0x00, rsp_valid = 0, rsp_rdata = 0x00, counters = 0.
REQ-035 req_ready SHALL be 0 while rst = 1.
REQ-036 Reset during STROBE SHALL drop wr_en on that same edge; any in-flight operation, including a pending read response, SHALL be discarded.

Verification
REQ-037 Defaults; write addr 0x2A data 0xC3 -> mem_ui_in 0x2A for 1 cycle, then 0xAA for 1 cycle, then 0x2A for 1 cycle; mem_uio_in 0xC3 throughout; req_ready returns in cycle 4.
REQ-038 After REQ-037, read addr 0x2A with memory model returning 0xC3 -> rsp_valid in cycle 4, rsp_rdata 0xC3.
REQ-039 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0, new req_valid ignored; rsp_ready = 1 -> IDLE on the next edge.
REQ-040 rst asserted during STROBE -> wr_en 0 after that edge, all outputs at their reset values, no rsp_valid; a subsequent write to 0x3F completes normally.
REQ-041 SETUP_CYCLES=3, WE_CYCLES=2, HOLD_CYCLES=4, READ_WAIT=5; back-to-back write/read on addresses 0x00 and 0x3F -> exact per-state cycle counts, and address never changes while wr_en = 1.
